vn_output_collector: RTL and testbench

Sink-side partner of the edge/adder switches in the reduction network. It captures the per-switch VN outputs (o_vn / o_vn_valid) from NUM_SW switches in the same cycle and stores each capture as a snapshot in a 2-deep bank buffer. It then serializes the valid results one per cycle, in lane order, onto a valid/ready stream toward the output buffer. The reduction network cannot stall, so captures that find no free bank are dropped and flagged.

---
 rtl/vn_output_collector.sv | 112 +++++++++++
 tb/tb_vn_output_collector.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vn_output_collector.sv
// Sink-side collector for the reduction network: snapshots all switch VN outputs
// into a 2-bank buffer and serializes valid lanes, in lane order, onto a valid/ready stream.
module vn_output_collector #(
    parameter int DATA_TYPE = 32,
    parameter int NUM_SW    = 4,
    parameter int LANE_BITS = 3
) (
    input  logic                          CLK,
    input  logic                          rst,
    input  logic [2*DATA_TYPE*NUM_SW-1:0] i_vn,
    input  logic [2*NUM_SW-1:0]           i_vn_valid,
    output logic [DATA_TYPE-1:0]          o_data,
    output logic [LANE_BITS-1:0]          o_lane,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_busy,
    output logic                          o_overflow,
    input  logic                          i_clr_overflow,
    output logic [15:0]                   o_count
);

    localparam int LANES = 2 * NUM_SW;

    if (LANE_BITS != $clog2(LANES)) begin : g_bad_lane_bits
        $error("vn_output_collector: LANE_BITS must equal clog2(2*NUM_SW)");
    end

    logic [DATA_TYPE-1:0] bank_data [2][LANES];
    logic [LANES-1:0]     mask [2];
    logic [1:0]           full;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic                 overflow;
    logic [15:0]          count;

    logic                 capture;
    logic                 capture_ok;
    logic                 capture_drop;
    logic                 fire;
    logic [LANES-1:0]     rd_mask;
    logic [LANES-1:0]     rd_onehot;
    logic [LANES-1:0]     rd_mask_next;
    logic [LANE_BITS-1:0] rd_lane;

    assign capture      = |i_vn_valid;
    // Only the start-of-cycle full flag matters: a bank released this cycle is not reusable yet.
    assign capture_ok   = capture & ~full[wr_ptr];
    assign capture_drop = capture & full[wr_ptr];

    assign rd_mask      = mask[rd_ptr];
    assign rd_onehot    = rd_mask & (~rd_mask + LANES'(1));
    assign rd_mask_next = rd_mask & ~rd_onehot;

    always_comb begin
        rd_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (rd_mask[i]) begin
                rd_lane = LANE_BITS'(i);
            end
        end
    end

    assign o_valid    = full[rd_ptr];
    assign o_lane     = rd_lane;
    assign o_data     = bank_data[rd_ptr][rd_lane];
    assign o_busy     = full[0] & full[1];
    assign o_overflow = overflow;
    assign o_count    = count;
    assign fire       = o_valid & i_ready;

    // Capture and release never target the same bank: a capture needs a non-full
    // write bank, a release needs a full read bank.
    always_ff @(posedge CLK) begin
        if (rst) begin
            full     <= '0;
            mask[0]  <= '0;
            mask[1]  <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            overflow <= 1'b0;
            count    <= '0;
        end else begin
            if (capture_ok) begin
                mask[wr_ptr] <= i_vn_valid;
                full[wr_ptr] <= 1'b1;
                wr_ptr       <= ~wr_ptr;
            end
            if (fire) begin
                mask[rd_ptr] <= rd_mask_next;
                count        <= count + 16'd1;
                if (rd_mask_next == '0) begin
                    full[rd_ptr] <= 1'b0;
                    rd_ptr       <= ~rd_ptr;
                end
            end
            if (capture_drop) begin
                overflow <= 1'b1;
            end else if (i_clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (capture_ok) begin
            for (int j = 0; j < LANES; j++) begin
                bank_data[wr_ptr][j] <= i_vn[DATA_TYPE*j +: DATA_TYPE];
            end
        end
    end

endmodule

// File: tb/tb_vn_output_collector.sv
// Directed self-checking bench for vn_output_collector.
module tb_vn_output_collector;

    logic         CLK = 1'b0;
    logic         rst;
    logic [255:0] i_vn;
    logic [7:0]   i_vn_valid;
    logic [31:0]  o_data;
    logic [2:0]   o_lane;
    logic         o_valid;
    logic         i_ready;
    logic         o_busy;
    logic         o_overflow;
    logic         i_clr_overflow;
    logic [15:0]  o_count;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    vn_output_collector #(.DATA_TYPE(32), .NUM_SW(4), .LANE_BITS(3)) dut (
        .CLK            (CLK),
        .rst            (rst),
        .i_vn           (i_vn),
        .i_vn_valid     (i_vn_valid),
        .o_data         (o_data),
        .o_lane         (o_lane),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_busy         (o_busy),
        .o_overflow     (o_overflow),
        .i_clr_overflow (i_clr_overflow),
        .o_count        (o_count)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        i_vn_valid     = '0;
        i_clr_overflow = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        i_vn    = '0;
        i_ready = 1'b1;
        do_reset();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", o_valid); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", o_busy); end
        total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%0b want=0", o_overflow); end
        total++; if (o_count !== 16'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", o_count); end
    endtask

    task automatic test_single();
        do_reset();
        i_ready         = 1'b1;
        i_vn            = '0;
        i_vn[96 +: 32]  = 32'h3F80_0000;
        i_vn_valid      = 8'b0000_1000;
        tick();
        i_vn_valid = '0;
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", o_valid); end
        total++; if (o_lane !== 3'd3) begin bad++; $display("FAIL single_lane got=%0d want=3", o_lane); end
        total++; if (o_data !== 32'h3F80_0000) begin bad++; $display("FAIL single_data got=%h want=3f800000", o_data); end
        tick();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL single_idle got=%0b want=0", o_valid); end
        total++; if (o_count !== 16'd1) begin bad++; $display("FAIL single_count got=%0d want=1", o_count); end
    endtask

    task automatic test_lane_order();
        logic [2:0]  exp_lane [3];
        logic [31:0] exp_data [3];
        exp_lane = '{3'd0, 3'd2, 3'd7};
        exp_data = '{32'hA0, 32'hA2, 32'hA7};
        do_reset();
        i_ready = 1'b1;
        for (int j = 0; j < 8; j++) i_vn[32*j +: 32] = 32'hA0 + 32'(j);
        i_vn_valid = 8'b1000_0101;
        tick();
        i_vn_valid = '0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (o_valid !== 1'b1 || o_lane !== exp_lane[k] || o_data !== exp_data[k]) begin
                bad++;
                $display("FAIL order_%0d got v=%0b lane=%0d data=%h want v=1 lane=%0d data=%h",
                         k, o_valid, o_lane, o_data, exp_lane[k], exp_data[k]);
            end
            tick();
        end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL order_idle got=%0b want=0", o_valid); end
        total++; if (o_count !== 16'd3) begin bad++; $display("FAIL order_count got=%0d want=3", o_count); end
    endtask

    task automatic test_overflow();
        do_reset();
        i_ready = 1'b0;
        i_vn    = '0;
        for (int k = 1; k <= 3; k++) begin
            i_vn[31:0] = 32'(k);
            i_vn_valid = 8'h01;
            tick();
            if (k == 2) begin
                total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL ovf_busy got=%0b want=1", o_busy); end
                total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0b want=0", o_overflow); end
            end
        end
        i_vn_valid = '0;
        total++; if (o_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b want=1", o_overflow); end
        tick();
        total++;
        if (o_valid !== 1'b1 || o_data !== 32'd1 || o_lane !== 3'd0) begin
            bad++; $display("FAIL ovf_hold got v=%0b lane=%0d data=%0d want v=1 lane=0 data=1", o_valid, o_lane, o_data);
        end
        i_ready = 1'b1;
        tick();
        total++;
        if (o_valid !== 1'b1 || o_data !== 32'd2) begin
            bad++; $display("FAIL ovf_second got v=%0b data=%0d want v=1 data=2", o_valid, o_data);
        end
        tick();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%0b want=0", o_valid); end
        total++; if (o_count !== 16'd2) begin bad++; $display("FAIL ovf_count got=%0d want=2", o_count); end
        total++; if (o_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b want=1", o_overflow); end
        i_clr_overflow = 1'b1;
        tick();
        i_clr_overflow = 1'b0;
        total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b want=0", o_overflow); end
    endtask

    task automatic test_collision();
        do_reset();
        i_ready     = 1'b0;
        i_vn        = '0;
        i_vn[31:0]  = 32'h11;
        i_vn_valid  = 8'h01;
        tick();
        i_vn        = '0;
        i_vn[64 +: 32] = 32'h22;
        i_vn_valid  = 8'h04;
        tick();
        // Bank 0 holds one pending bit; its release collides with a new capture.
        i_vn        = '0;
        i_vn[32 +: 32] = 32'h33;
        i_vn_valid  = 8'h02;
        i_ready     = 1'b1;
        tick();
        i_vn_valid = '0;
        total++; if (o_overflow !== 1'b1) begin bad++; $display("FAIL coll_overflow got=%0b want=1", o_overflow); end
        total++;
        if (o_valid !== 1'b1 || o_lane !== 3'd2 || o_data !== 32'h22) begin
            bad++; $display("FAIL coll_next got v=%0b lane=%0d data=%h want v=1 lane=2 data=22", o_valid, o_lane, o_data);
        end
        tick();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL coll_dropped got=%0b want=0", o_valid); end
        total++; if (o_count !== 16'd2) begin bad++; $display("FAIL coll_count got=%0d want=2", o_count); end
    endtask

    // Runs straight after test_collision so o_overflow enters the reset still set.
    task automatic test_reset_mid_drain();
        i_ready = 1'b1;
        for (int j = 0; j < 8; j++) i_vn[32*j +: 32] = 32'hB0 + 32'(j);
        i_vn_valid = 8'hFF;
        tick();
        i_vn_valid = '0;
        tick(); tick(); tick();
        total++;
        if (o_count !== 16'd5 || o_lane !== 3'd3) begin
            bad++; $display("FAIL mid_progress got count=%0d lane=%0d want count=5 lane=3", o_count, o_lane);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b want=0", o_valid); end
        total++; if (o_count !== 16'd0) begin bad++; $display("FAIL mid_count got=%0d want=0", o_count); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b want=0", o_busy); end
        total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL mid_overflow got=%0b want=0", o_overflow); end
        for (int j = 0; j < 8; j++) i_vn[32*j +: 32] = 32'hC0 + 32'(j);
        i_vn_valid = 8'h11;
        tick();
        i_vn_valid = '0;
        total++;
        if (o_valid !== 1'b1 || o_lane !== 3'd0 || o_data !== 32'hC0) begin
            bad++; $display("FAIL mid_fresh0 got v=%0b lane=%0d data=%h want v=1 lane=0 data=c0", o_valid, o_lane, o_data);
        end
        tick();
        total++;
        if (o_valid !== 1'b1 || o_lane !== 3'd4 || o_data !== 32'hC4) begin
            bad++; $display("FAIL mid_fresh4 got v=%0b lane=%0d data=%h want v=1 lane=4 data=c4", o_valid, o_lane, o_data);
        end
        tick();
        total++; if (o_count !== 16'd2) begin bad++; $display("FAIL mid_fresh_count got=%0d want=2", o_count); end
    endtask

    task automatic test_count_wrap();
        int errs;
        errs = 0;
        do_reset();
        i_ready = 1'b1;
        for (int i = 0; i <= 65536; i++) begin
            i_vn = '0;
            i_vn[32*(i%8) +: 32] = 32'(i);
            i_vn_valid = 8'(1 << (i % 8));
            tick();
            // Capture i is now on the output and captures 0..i-1 have been handshaken.
            if (o_valid !== 1'b1 || o_data !== 32'(i) || o_lane !== 3'(i % 8) || o_count !== 16'(i)) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL wrap_step_%0d got v=%0b lane=%0d data=%0d count=%0d want v=1 lane=%0d data=%0d count=%0d",
                             i, o_valid, o_lane, o_data, o_count, i % 8, i, i % 65536);
            end
            if (i == 65535) begin
                total++; if (o_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff got=%h want=ffff", o_count); end
            end
            if (i == 65536) begin
                total++; if (o_count !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h want=0000", o_count); end
            end
        end
        i_vn_valid = '0;
        tick();
        total++; if (errs != 0) begin bad++; $display("FAIL wrap_stream got errors=%0d want 0", errs); end
        total++; if (o_count !== 16'd1) begin bad++; $display("FAIL wrap_final got=%0d want=1", o_count); end
        total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL wrap_overflow got=%0b want=0", o_overflow); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL wrap_idle got=%0b want=0", o_valid); end
    endtask

    initial begin
        rst            = 1'b1;
        i_vn           = '0;
        i_vn_valid     = '0;
        i_ready        = 1'b0;
        i_clr_overflow = 1'b0;
        #2;
        test_reset();
        test_single();
        test_lane_order();
        test_overflow();
        test_collision();
        test_reset_mid_drain();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
